// File: rtl/matmul_defs.sv
// ---------------------------------------------------------------------------
// matmul_defs
//   Shared definitions for the tile matrix-multiply engine.
//   - Default tile geometry and fixed-point format (Q8.8, 4x4).
//   - Accumulator width formula and packed-vector index helper.
//   - Narrowing helpers (range test and saturating clamp) for results.
//   - FSM state encoding.
// ---------------------------------------------------------------------------
package matmul_defs;

    localparam int DEF_N      = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;

    // Width the narrowing helpers work in. Accumulator sums are sign-extended
    // into this width, so ACC_W must stay below it.
    localparam int NARROW_W = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Exact width of N shifted full-width products plus an accumulated C term.
    function automatic int acc_width(input int n, input int data_w);
        return 2 * data_w + $clog2(n) + 1;
    endfunction

    // LSB position of element [row][col] in an n x n packed tile.
    function automatic int pack_lsb(input int row, input int col, input int n, input int data_w);
        return (row * n + col) * data_w;
    endfunction

    function automatic logic signed [NARROW_W-1:0] max_val(input int data_w);
        return (64'sd1 <<< (data_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [NARROW_W-1:0] min_val(input int data_w);
        return -(64'sd1 <<< (data_w - 1));
    endfunction

    // True when v does not fit a signed data_w-bit element.
    function automatic logic out_of_range(input logic signed [NARROW_W-1:0] v, input int data_w);
        return (v > max_val(data_w)) || (v < min_val(data_w));
    endfunction

    // Clamp to the data_w range when sat is set; otherwise pass v through so
    // that truncating to data_w bits gives the wrapped result.
    function automatic logic [NARROW_W-1:0] narrow_value(input logic signed [NARROW_W-1:0] v,
                                                         input int data_w, input logic sat);
        if (sat && (v > max_val(data_w))) begin
            return max_val(data_w);
        end else if (sat && (v < min_val(data_w))) begin
            return min_val(data_w);
        end
        return v;
    endfunction

endpackage

// File: rtl/matmul_dot_unit.sv
// ---------------------------------------------------------------------------
// matmul_dot_unit
//   Combinational dot product of one A row and one B column.
//   Each product is full width, arithmetically shifted right by FRAC_W
//   (floor), sign-extended to ACC_W and summed exactly.
// Ports:
//   a_row  in  N*DATA_W  A[i][k] at [k*DATA_W +: DATA_W]
//   b_col  in  N*DATA_W  B[k][j] at [k*DATA_W +: DATA_W]
//   dot    out ACC_W     signed sum of shifted products
// ---------------------------------------------------------------------------
module matmul_dot_unit #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 35
) (
    input  logic [N*DATA_W-1:0]    a_row,
    input  logic [N*DATA_W-1:0]    b_col,
    output logic signed [ACC_W-1:0] dot
);

    logic signed [ACC_W-1:0] term [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            logic signed [2*DATA_W-1:0] prod;
            assign prod     = $signed(a_row[gi*DATA_W +: DATA_W]) * $signed(b_col[gi*DATA_W +: DATA_W]);
            assign term[gi] = ACC_W'(prod >>> FRAC_W);
        end
    endgenerate

    always_comb begin
        dot = '0;
        for (int k = 0; k < N; k++) begin
            dot = dot + term[k];
        end
    end

endmodule

// File: rtl/block_matmul_engine.sv
// ---------------------------------------------------------------------------
// block_matmul_engine
//   Computes one NxN tile product C = A*B or C += A*B on signed fixed-point
//   elements, one C element per cycle, with a start/busy/done handshake.
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset; clears all state and C
//   start       in   job request, sampled only while idle
//   accumulate  in   1: C += A*B, 0: C = A*B (latched at accept)
//   sat_en      in   1: saturate, 0: wrap (latched at accept)
//   a_rows      in   A[i][k] at [(i*N+k)*DATA_W +: DATA_W]
//   b_cols      in   B[k][j] at [(j*N+k)*DATA_W +: DATA_W]
//   busy        out  job in progress
//   done        out  one-cycle pulse when c_tile is complete
//   overflow    out  sticky per job: some element left the DATA_W range
//   c_tile      out  C[i][j] at [(i*N+j)*DATA_W +: DATA_W]
// Timing: accepting edge is edge 0; element e = i*N+j is issued to the dot
// unit during cycle e+1, its sum registered at edge e+1, and C written at
// edge e+2. done rises on the edge of the last write (N*N+1).
// ---------------------------------------------------------------------------
module block_matmul_engine
    import matmul_defs::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  accumulate,
    input  logic                  sat_en,
    input  logic [N*N*DATA_W-1:0] a_rows,
    input  logic [N*N*DATA_W-1:0] b_cols,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [N*N*DATA_W-1:0] c_tile
);

    localparam int ACC_W  = acc_width(N, DATA_W);
    localparam int IDX_W  = $clog2(N);
    localparam int E_W    = $clog2(N * N);
    localparam int ROW_W  = N * DATA_W;
    localparam int TILE_W = N * N * DATA_W;

    state_t                   state_reg, state_next;
    logic [TILE_W-1:0]        a_reg, b_reg;
    logic                     acc_mode_reg, sat_mode_reg;
    logic [IDX_W-1:0]         i_reg, j_reg;
    logic                     issue_reg;
    logic signed [ACC_W-1:0]  dot_sum, dot_reg;
    logic                     wr_valid_reg;
    logic [E_W-1:0]           wr_idx_reg;
    logic signed [DATA_W-1:0] c_reg [N*N];
    logic                     done_reg, overflow_reg;
    logic                     accept, last_write;
    logic signed [NARROW_W-1:0] wr_sum;

    // Row i of A and column j of B are contiguous in the latched operands.
    matmul_dot_unit #(
        .N      (N),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_dot (
        .a_row (a_reg[int'(i_reg)*ROW_W +: ROW_W]),
        .b_col (b_reg[int'(j_reg)*ROW_W +: ROW_W]),
        .dot   (dot_sum)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_write = wr_valid_reg && (wr_idx_reg == E_W'(N * N - 1));
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_write) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Value about to be written: registered dot product plus, when
    // accumulating, the element's previous contents.
    always_comb begin
        wr_sum = NARROW_W'(dot_reg);
        if (acc_mode_reg) begin
            wr_sum = wr_sum + NARROW_W'(c_reg[wr_idx_reg]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            acc_mode_reg <= 1'b0;
            sat_mode_reg <= 1'b0;
            i_reg        <= '0;
            j_reg        <= '0;
            issue_reg    <= 1'b0;
            dot_reg      <= '0;
            wr_valid_reg <= 1'b0;
            wr_idx_reg   <= '0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            for (int e = 0; e < N * N; e++) begin
                c_reg[e] <= '0;
            end
        end else begin
            done_reg     <= last_write;
            wr_valid_reg <= issue_reg;

            if (issue_reg) begin
                dot_reg    <= dot_sum;
                wr_idx_reg <= E_W'(int'(i_reg) * N + int'(j_reg));
                if (j_reg == IDX_W'(N - 1)) begin
                    j_reg <= '0;
                    if (i_reg == IDX_W'(N - 1)) begin
                        i_reg     <= '0;
                        issue_reg <= 1'b0;
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end else begin
                    j_reg <= j_reg + 1'b1;
                end
            end

            if (wr_valid_reg) begin
                c_reg[wr_idx_reg] <= DATA_W'(narrow_value(wr_sum, DATA_W, sat_mode_reg));
                if (out_of_range(wr_sum, DATA_W)) begin
                    overflow_reg <= 1'b1;
                end
            end

            // Only possible while idle, when no issue or write is in flight.
            if (accept) begin
                a_reg        <= a_rows;
                b_reg        <= b_cols;
                acc_mode_reg <= accumulate;
                sat_mode_reg <= sat_en;
                i_reg        <= '0;
                j_reg        <= '0;
                issue_reg    <= 1'b1;
                overflow_reg <= 1'b0;
            end
        end
    end

    assign busy     = (state_reg == ST_RUN);
    assign done     = done_reg;
    assign overflow = overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N * N; gi++) begin : g_ctile
            assign c_tile[gi*DATA_W +: DATA_W] = c_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_block_matmul_engine.sv
// ---------------------------------------------------------------------------
// tb_block_matmul_engine
//   Directed bench for the 4x4 Q8.8 configuration. Each scenario task drives
//   a job, then compares timing, hand-computed elements and the whole tile
//   against a small fixed-point reference model of C.
// ---------------------------------------------------------------------------
module tb_block_matmul_engine;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic         accumulate;
    logic         sat_en;
    logic [255:0] a_rows;
    logic [255:0] b_cols;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [255:0] c_tile;

    int vectors     = 0;
    int miscompares = 0;

    shortint a_m [4][4];      // A[i][k]
    shortint b_m [4][4];      // B[k][j]
    shortint c_model [4][4];  // expected C[i][j]
    logic    ovf_model;

    int a_base [4][4] = '{'{0, 1, 2, 3}, '{4, 5, 6, 7}, '{8, 9, 1, 1}, '{2, 3, 4, 5}};
    int b_colv [4][4] = '{'{0, 4, 8, 1}, '{1, 5, 9, 1}, '{2, 6, 1, 4}, '{3, 7, 1, 5}}; // [j][k]

    block_matmul_engine #(.N(4), .DATA_W(16), .FRAC_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .sat_en     (sat_en),
        .a_rows     (a_rows),
        .b_cols     (b_cols),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .c_tile     (c_tile)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] c_at(input int i, input int j);
        return c_tile[(i*4+j)*16 +: 16];
    endfunction

    function automatic logic [255:0] pack_model();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                v[(i*4+j)*16 +: 16] = c_model[i][j];
        return v;
    endfunction

    task automatic set_base();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = shortint'(a_base[i][k] * 256);
                b_m[k][i] = shortint'(b_colv[i][k] * 256);
            end
    endtask

    task automatic set_uniform(input shortint av, input shortint bv, input bit a_identity);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_m[i][k] = a_identity ? ((i == k) ? av : 16'sd0) : av;
                b_m[i][k] = bv;
            end
    endtask

    task automatic drive_operands();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                a_rows[(i*4+k)*16 +: 16] = a_m[i][k];
                b_cols[(i*4+k)*16 +: 16] = b_m[k][i];  // column i, row k
            end
    endtask

    // Reference: floor-shifted products summed exactly, optional accumulate,
    // then clamp or wrap to 16 bits.
    task automatic model_job(input logic acc, input logic sat);
        ovf_model = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                longint s;
                s = 0;
                for (int k = 0; k < 4; k++)
                    s += (longint'(a_m[i][k]) * longint'(b_m[k][j])) >>> 8;
                if (acc) s += longint'(c_model[i][j]);
                if (s > 32767 || s < -32768) ovf_model = 1'b1;
                if (sat && s > 32767)       c_model[i][j] = 16'sh7FFF;
                else if (sat && s < -32768) c_model[i][j] = -16'sh8000;
                else                        c_model[i][j] = shortint'(s);
            end
    endtask

    // Starts at a negedge with start low; returns the edge index of done
    // (-1 if it never came within the budget). Inputs are scrambled after
    // the accepting edge to show they are latched.
    task automatic run_job(input logic acc, input logic sat, output int done_edge);
        drive_operands();
        accumulate = acc;
        sat_en     = sat;
        start      = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start      = 1'b0;
        a_rows     = ~a_rows;
        b_cols     = ~b_cols;
        accumulate = ~acc;
        sat_en     = ~sat;
        done_edge  = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                done_edge = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; accumulate = 1'b0; sat_en = 1'b0;
        a_rows = '0; b_cols = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c_model[i][j] = 0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({busy, done, overflow} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: busy/done/ovf got %b required 000", {busy, done, overflow});
        end
        vectors++;
        if (c_tile !== '0) begin
            miscompares++;
            $display("FAIL reset_ctile: got %h required 0", c_tile);
        end
        reset = 1'b1;
        @(negedge clock);
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        int de;
        set_base();
        model_job(1'b0, 1'b1);
        run_job(1'b0, 1'b1, de);
        vectors++;
        if (de !== 17) begin miscompares++; $display("FAIL basic_done_edge: got %0d required 17", de); end
        vectors++;
        if (c_at(0, 0) !== 16'h1700) begin miscompares++; $display("FAIL basic_c00: got %h required 1700", c_at(0, 0)); end
        vectors++;
        if (c_at(1, 1) !== 16'h5A00) begin miscompares++; $display("FAIL basic_c11: got %h required 5a00", c_at(1, 1)); end
        vectors++;
        if (c_at(2, 2) !== 16'h4B00) begin miscompares++; $display("FAIL basic_c22: got %h required 4b00", c_at(2, 2)); end
        vectors++;
        if (overflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_ovf_busy: got %b%b required 00", overflow, busy);
        end
        vectors++;
        if (c_tile !== pack_model()) begin miscompares++; $display("FAIL basic_tile: got %h required %h", c_tile, pack_model()); end
        $display("test_basic: done edge %0d, C00=%h C11=%h C22=%h ovf=%b", de, c_at(0, 0), c_at(1, 1), c_at(2, 2), overflow);
    endtask

    task automatic test_accumulate();
        int de;
        set_base();
        model_job(1'b1, 1'b1);
        run_job(1'b1, 1'b1, de);
        vectors++;
        if (de !== 17) begin miscompares++; $display("FAIL acc_done_edge: got %0d required 17", de); end
        vectors++;
        if (c_at(0, 0) !== 16'h2E00) begin miscompares++; $display("FAIL acc_c00: got %h required 2e00", c_at(0, 0)); end
        vectors++;
        if (c_at(1, 1) !== 16'h7FFF) begin miscompares++; $display("FAIL acc_c11_sat: got %h required 7fff", c_at(1, 1)); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL acc_ovf: got %b required 1", overflow); end
        vectors++;
        if (c_tile !== pack_model()) begin miscompares++; $display("FAIL acc_tile: got %h required %h", c_tile, pack_model()); end
        $display("test_accumulate: C00=%h C11=%h ovf=%b", c_at(0, 0), c_at(1, 1), overflow);
    endtask

    task automatic test_saturate_wrap();
        int de;
        set_uniform(16'sh7F00, 16'sh7F00, 1'b0);
        model_job(1'b0, 1'b1);
        run_job(1'b0, 1'b1, de);
        vectors++;
        if (c_tile !== {16{16'h7FFF}}) begin miscompares++; $display("FAIL sat_tile: got %h required all 7fff", c_tile); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL sat_ovf: got %b required 1", overflow); end
        $display("test_saturate: C00=%h ovf=%b", c_at(0, 0), overflow);
        model_job(1'b0, 1'b0);
        run_job(1'b0, 1'b0, de);
        vectors++;
        if (c_tile !== {16{16'h0400}}) begin miscompares++; $display("FAIL wrap_tile: got %h required all 0400", c_tile); end
        vectors++;
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL wrap_ovf: got %b required 1", overflow); end
        $display("test_wrap: C33=%h ovf=%b", c_at(3, 3), overflow);
    endtask

    task automatic test_signed_floor();
        int de;
        set_uniform(-16'sh0100, 16'sh0080, 1'b1);
        model_job(1'b0, 1'b1);
        run_job(1'b0, 1'b1, de);
        vectors++;
        if (c_tile !== {16{16'hFF80}}) begin miscompares++; $display("FAIL neg_half_tile: got %h required all ff80", c_tile); end
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL neg_half_ovf: got %b required 0", overflow); end
        $display("test_signed: C00=%h ovf=%b", c_at(0, 0), overflow);
        set_uniform(-16'sh0100, 16'sh0001, 1'b1);
        model_job(1'b0, 1'b1);
        run_job(1'b0, 1'b1, de);
        vectors++;
        if (c_tile !== {16{16'hFFFF}}) begin miscompares++; $display("FAIL floor_tile: got %h required all ffff", c_tile); end
        $display("test_floor: C12=%h", c_at(1, 2));
    endtask

    task automatic test_start_ignored();
        int dones, first;
        dones = 0; first = -1;
        set_base();
        model_job(1'b0, 1'b1);
        drive_operands();
        accumulate = 1'b0; sat_en = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int k = 1; k <= 30; k++) begin
            start = (k == 3 || k == 10);
            @(posedge clock);
            @(negedge clock);
            if (done) begin
                dones++;
                if (first < 0) first = k;
            end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 1 || first !== 17) begin
            miscompares++; $display("FAIL busy_start: got %0d dones first at %0d required 1 at 17", dones, first);
        end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_start_idle: got busy %b required 0", busy); end
        vectors++;
        if (c_tile !== pack_model()) begin miscompares++; $display("FAIL busy_start_tile: got %h required %h", c_tile, pack_model()); end
        $display("test_start_ignored: %0d done pulse(s), first at edge %0d", dones, first);
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic busy18;
        first = -1; second = -1; busy18 = 1'b0;
        set_base();
        model_job(1'b0, 1'b1);
        model_job(1'b0, 1'b1);
        drive_operands();
        accumulate = 1'b0; sat_en = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 18) begin
                busy18 = busy;
                start  = 1'b0;
            end
            if (done) begin
                if (first < 0) first = k;
                else begin second = k; break; end
            end
        end
        start = 1'b0;
        vectors++;
        if (first !== 17 || second !== 35) begin
            miscompares++; $display("FAIL b2b_done_edges: got %0d,%0d required 17,35", first, second);
        end
        vectors++;
        if (busy18 !== 1'b1) begin miscompares++; $display("FAIL b2b_busy18: got %b required 1", busy18); end
        vectors++;
        if (c_tile !== pack_model()) begin miscompares++; $display("FAIL b2b_tile: got %h required %h", c_tile, pack_model()); end
        $display("test_back_to_back: done at edges %0d and %0d", first, second);
    endtask

    task automatic test_reset_mid_job();
        int de;
        set_base();
        drive_operands();
        accumulate = 1'b0; sat_en = 1'b1; start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (7) @(negedge clock);
        @(posedge clock);          // edge 8
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL midreset_flags: got busy/done %b required 00", {busy, done}); end
        vectors++;
        if (c_tile !== '0) begin miscompares++; $display("FAIL midreset_ctile: got %h required 0", c_tile); end
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c_model[i][j] = 0;
        @(negedge clock);
        model_job(1'b0, 1'b1);
        drive_operands();
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        de = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) begin
                vectors++;
                if (c_at(0, 0) !== 16'h0000) begin miscompares++; $display("FAIL lat_c00_e1: got %h required 0000", c_at(0, 0)); end
            end
            if (k == 2) begin
                vectors++;
                if (c_at(0, 0) !== 16'h1700) begin miscompares++; $display("FAIL lat_c00_e2: got %h required 1700", c_at(0, 0)); end
            end
            if (k == 16) begin
                vectors++;
                if (c_at(3, 3) !== 16'h0000 || busy !== 1'b1 || done !== 1'b0) begin
                    miscompares++; $display("FAIL lat_c33_e16: got %h busy %b done %b required 0000 1 0", c_at(3, 3), busy, done);
                end
            end
            if (done) begin de = k; break; end
        end
        vectors++;
        if (de !== 17) begin miscompares++; $display("FAIL rerun_done_edge: got %0d required 17", de); end
        vectors++;
        if (c_tile !== pack_model()) begin miscompares++; $display("FAIL rerun_tile: got %h required %h", c_tile, pack_model()); end
        $display("test_reset_mid_job: rerun done at edge %0d, C00=%h", de, c_at(0, 0));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_accumulate();
        test_saturate_wrap();
        test_signed_floor();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
